nb_rotate_ring: RTL and testbench
=================================

// Module: nb_rotate_ring
// PURPOSE
//  Parametrised register ring showing nonblocking parallel update across DEPTH stages of WIDTH bits.
//  Each active cycle computes every stage's next value from the current values only.
//  Modes: hold, rotate left, rotate right, serial shift-in. Parallel load overrides the mode.
//  A position counter with a wrap pulse tracks the net rotation.
//  Generalises the fixed 4-word a<=b, b<=c, c<=d, d<=a ring demo.
// PARAMETERS
//  WIDTH      32  bits per stage (>=1)
//  DEPTH      4   number of stages (>=2; need not be a power of 2)
//  INIT_BASE  1   reset value of stage i is (INIT_BASE+i) mod 2**WIDTH
// PORTS
//  clock       in   1            single clock; all state updates on posedge
//  reset       in   1            synchronous, active-high reset
//  en          in   1            advance enable; when 0 the ring holds (load still acts)
//  mode        in   2            00 hold, 01 rotate left, 10 rotate right, 11 shift-in
//  din         in   WIDTH        serial input word for shift-in mode
//  load        in   1            parallel load strobe
//  ld_data     in   DEPTH*WIDTH  load data; stage i = ld_data[i*WIDTH +: WIDTH]
//  q           out  DEPTH*WIDTH  stage contents; stage i = q[i*WIDTH +: WIDTH]
//  dout        out  WIDTH        word shifted out of stage 0 in shift-in mode
//  dout_valid  out  1            1-cycle pulse: dout was updated this cycle
//  pos         out  PW           net rotation mod DEPTH; PW = $clog2(DEPTH)
//  wrap        out  1            1-cycle pulse: pos crossed between DEPTH-1 and 0
// BEHAVIOUR
//  Reset (reset=1 at posedge):
//   - stage i = INIT_BASE+i.
//   - dout=0, dout_valid=0, pos=0, wrap=0.
//   - Reset overrides load/en/mode; a reset mid-sequence discards all progress in that cycle.
//  Priority per cycle: reset > load > (en & mode) > hold.
//  Load: every stage <= its ld_data slice; pos <= 0; wrap <= 0; dout holds; dout_valid <= 0.
//  en=1, mode=01 (rotate left):
//   - stage i <= stage i+1 for i<DEPTH-1; stage DEPTH-1 <= stage 0.
//   - pos <= (pos==DEPTH-1) ? 0 : pos+1; wrap <= 1 only when pos was DEPTH-1.
//  en=1, mode=10 (rotate right):
//   - stage i <= stage i-1 for i>0; stage 0 <= stage DEPTH-1.
//   - pos <= (pos==0) ? DEPTH-1 : pos-1; wrap <= 1 only when pos was 0.
//  en=1, mode=11 (shift-in):
//   - stage i <= stage i+1; stage DEPTH-1 <= din.
//   - dout <= old stage 0; dout_valid <= 1; pos unchanged; wrap <= 0.
//  en=0, or mode=00: all stages, pos and dout hold; dout_valid <= 0; wrap <= 0.
//  dout_valid is 0 on every cycle that is not a shift-in.
//  Latency: results visible on q/pos/dout one clock after the sampling edge. No combinational input->output path.
//  Stage swaps are lossless: no value is duplicated or dropped during rotation.
//  DEPTH not a power of 2: pos wraps by explicit compare, never by bit overflow.
//  Arithmetic: INIT_BASE+i truncates to WIDTH bits; pos is unsigned.
// TESTING (DEPTH=4, WIDTH=32, INIT_BASE=1; q listed stage0..3)
//  1. Reset 2 cycles -> q=1,2,3,4; pos=0, wrap=0, dout_valid=0.
//  2. en=1, mode=01, 1 cycle -> q=2,3,4,1, pos=1.
//     Continue 3 more cycles -> q=1,2,3,4, pos=0; wrap=1 on the 4th cycle only.
//  3. From reset: mode=10, 1 cycle -> q=4,1,2,3, pos=3, wrap=1. Next cycle -> q=3,4,1,2, pos=2, wrap=0.
//  4. From reset: mode=11, din=9, then din=10 -> q=2,3,4,9, dout=1, dout_valid=1;
//     then q=3,4,9,10, dout=2. Drop en -> dout_valid=0, q holds.
//  5. load=1 with en=1, mode=01, ld_data=5,6,7,8 -> q=5,6,7,8, pos=0 (load wins).
//     Then en=0 for 3 cycles -> q unchanged.
//  6. Rotate left 2 cycles, then reset with load=1, en=1 asserted -> q=1,2,3,4, pos=0, wrap=0.

Source files
------------

// File: rtl/nb_rotate_ring.sv
// rtl/nb_rotate_ring.sv - parametrised register ring with rotate, shift-in and parallel load
// Every stage's next value is computed from current values only, so the whole ring updates in parallel.
module nb_rotate_ring #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int INIT_BASE = 1,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       din,
  input  logic                   load,
  input  logic [DEPTH*WIDTH-1:0] ld_data,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [PW-1:0]          pos,
  output logic                   wrap
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] stage   [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [PW-1:0]    pos_d;
  logic             wrap_d;
  logic             dv_d;
  logic [WIDTH-1:0] dout_d;

  always_comb begin
    stage_d = stage;
    pos_d   = pos;
    wrap_d  = 1'b0;
    dv_d    = 1'b0;
    dout_d  = dout;
    if (load) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = ld_data[i*WIDTH +: WIDTH];
      end
      pos_d = '0;
    end else if (en) begin
      case (mode)
        2'b01: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage[(i + 1) % DEPTH];
          end
          // explicit compare so non-power-of-2 depths wrap correctly
          pos_d  = (pos == LAST) ? '0 : pos + PW'(1);
          wrap_d = (pos == LAST);
        end
        2'b10: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage[(i + DEPTH - 1) % DEPTH];
          end
          pos_d  = (pos == '0) ? LAST : pos - PW'(1);
          wrap_d = (pos == '0);
        end
        2'b11: begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage[i + 1];
          end
          stage_d[DEPTH-1] = din;
          dout_d           = stage[0];
          dv_d             = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= WIDTH'(INIT_BASE + i);
      end
      pos        <= '0;
      wrap       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      stage      <= stage_d;
      pos        <= pos_d;
      wrap       <= wrap_d;
      dout       <= dout_d;
      dout_valid <= dv_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_q
    assign q[g*WIDTH +: WIDTH] = stage[g];
  end

endmodule

// File: tb/tb_nb_rotate_ring.sv
// tb/tb_nb_rotate_ring.sv - table-driven scoreboard bench for nb_rotate_ring
module tb_nb_rotate_ring;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int PW = 2;
  localparam int QW = W * D;

  logic          clock = 1'b0;
  logic          reset, en, load;
  logic [1:0]    mode;
  logic [W-1:0]  din;
  logic [QW-1:0] ld_data;
  logic [QW-1:0] q;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [PW-1:0] pos;
  logic          wrap;

  nb_rotate_ring #(.WIDTH(W), .DEPTH(D), .INIT_BASE(1)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .din(din),
    .load(load), .ld_data(ld_data), .q(q), .dout(dout),
    .dout_valid(dout_valid), .pos(pos), .wrap(wrap)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst, en, load;
    logic [1:0]    mode;
    logic [W-1:0]  din;
    logic [QW-1:0] ld;
  } in_t;

  typedef struct {
    logic [QW-1:0] q;
    logic [PW-1:0] pos;
    logic          wrap, dv;
    logic [W-1:0]  dout;
    int            id;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [QW-1:0] w4(int a, int b, int c, int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic void add(logic r, logic e, logic [1:0] m, int dn, logic l, logic [QW-1:0] ld,
                              logic [QW-1:0] eq, int ep, logic ew, logic edv, int ed);
    vec_t v;
    v.i.rst = r; v.i.en = e; v.i.mode = m; v.i.din = 32'(dn); v.i.load = l; v.i.ld = ld;
    v.e.q = eq; v.e.pos = PW'(ep); v.e.wrap = ew; v.e.dv = edv; v.e.dout = 32'(ed);
    v.e.id = tbl.size();
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int id, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic step(input in_t i, input exp_t e);
    exp_t g;
    @(negedge clock);
    reset = i.rst; en = i.en; mode = i.mode; din = i.din; load = i.load; ld_data = i.ld;
    sb.push_back(e);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    chk("q",    g.id, q,                 g.q);
    chk("pos",  g.id, QW'(pos),          QW'(g.pos));
    chk("wrap", g.id, QW'(wrap),         QW'(g.wrap));
    chk("dv",   g.id, QW'(dout_valid),   QW'(g.dv));
    chk("dout", g.id, QW'(dout),         QW'(g.dout));
  endtask

  logic [W-1:0]  m [D];
  logic [W-1:0]  tmp;
  int            mpos;
  logic          mw, mdv;
  logic [W-1:0]  mdout;

  function automatic logic [QW-1:0] mq();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  initial begin
    logic [QW-1:0] z, l5, q1234;
    in_t  ri;
    exp_t re;
    reset = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00; din = '0; ld_data = '0;
    z = '0;
    l5 = w4(5, 6, 7, 8);
    q1234 = w4(1, 2, 3, 4);

    add(1, 0, 2'b00, 0, 0, z, q1234, 0, 0, 0, 0);
    add(1, 0, 2'b00, 0, 0, z, q1234, 0, 0, 0, 0);
    add(0, 1, 2'b01, 0, 0, z, w4(2, 3, 4, 1), 1, 0, 0, 0);
    add(0, 1, 2'b01, 0, 0, z, w4(3, 4, 1, 2), 2, 0, 0, 0);
    add(0, 1, 2'b01, 0, 0, z, w4(4, 1, 2, 3), 3, 0, 0, 0);
    add(0, 1, 2'b01, 0, 0, z, q1234, 0, 1, 0, 0);
    add(1, 0, 2'b00, 0, 0, z, q1234, 0, 0, 0, 0);
    add(0, 1, 2'b10, 0, 0, z, w4(4, 1, 2, 3), 3, 1, 0, 0);
    add(0, 1, 2'b10, 0, 0, z, w4(3, 4, 1, 2), 2, 0, 0, 0);
    add(1, 0, 2'b00, 0, 0, z, q1234, 0, 0, 0, 0);
    add(0, 1, 2'b11, 9, 0, z, w4(2, 3, 4, 9), 0, 0, 1, 1);
    add(0, 1, 2'b11, 10, 0, z, w4(3, 4, 9, 10), 0, 0, 1, 2);
    add(0, 0, 2'b11, 11, 0, z, w4(3, 4, 9, 10), 0, 0, 0, 2);
    add(0, 1, 2'b01, 0, 1, l5, l5, 0, 0, 0, 2);
    add(0, 0, 2'b01, 0, 0, z, l5, 0, 0, 0, 2);
    add(0, 0, 2'b10, 0, 0, z, l5, 0, 0, 0, 2);
    add(0, 0, 2'b11, 3, 0, z, l5, 0, 0, 0, 2);
    add(0, 1, 2'b01, 0, 0, z, w4(6, 7, 8, 5), 1, 0, 0, 2);
    add(0, 1, 2'b01, 0, 0, z, w4(7, 8, 5, 6), 2, 0, 0, 2);
    add(1, 1, 2'b01, 0, 1, l5, q1234, 0, 0, 0, 0);
    add(0, 1, 2'b10, 0, 0, z, w4(4, 1, 2, 3), 3, 1, 0, 0);
    add(0, 1, 2'b10, 0, 1, l5, l5, 0, 0, 0, 0);
    add(0, 1, 2'b00, 0, 0, z, l5, 0, 0, 0, 0);
    add(0, 1, 2'b11, 11, 0, z, w4(6, 7, 8, 11), 0, 0, 1, 5);
    add(0, 1, 2'b01, 0, 0, z, w4(7, 8, 11, 6), 1, 0, 0, 5);
    add(0, 1, 2'b11, 12, 1, l5, l5, 0, 0, 0, 5);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].i, tbl[k].e);
    end

    // Randomised phase checked against an independent behavioural model
    for (int k = 0; k < 300; k++) begin
      ri.rst  = (k == 0) || ($urandom_range(31) == 0);
      ri.load = ($urandom_range(7) == 0);
      ri.en   = ($urandom_range(4) != 0);
      ri.mode = 2'($urandom_range(3));
      ri.din  = $urandom;
      ri.ld   = {$urandom, $urandom, $urandom, $urandom};
      if (ri.rst) begin
        for (int s = 0; s < D; s++) m[s] = W'(s + 1);
        mpos = 0; mw = 0; mdv = 0; mdout = '0;
      end else if (ri.load) begin
        for (int s = 0; s < D; s++) m[s] = ri.ld[s*W +: W];
        mpos = 0; mw = 0; mdv = 0;
      end else if (ri.en && ri.mode == 2'b01) begin
        tmp = m[0]; m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = tmp;
        mw = (mpos == 3); mpos = (mpos + 1) % 4; mdv = 0;
      end else if (ri.en && ri.mode == 2'b10) begin
        tmp = m[3]; m[3] = m[2]; m[2] = m[1]; m[1] = m[0]; m[0] = tmp;
        mw = (mpos == 0); mpos = (mpos + 3) % 4; mdv = 0;
      end else if (ri.en && ri.mode == 2'b11) begin
        mdout = m[0]; m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = ri.din;
        mw = 0; mdv = 1;
      end else begin
        mw = 0; mdv = 0;
      end
      re.q = mq(); re.pos = PW'(mpos); re.wrap = mw; re.dv = mdv; re.dout = mdout;
      re.id = 1000 + k;
      step(ri, re);
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
